// File: rtl/lu_sweeper.sv
// Self-check driver for a 2-input logical unit. It walks the four {a,b} vectors,
// captures the unit's response into a 4-bit result and compares it with the function code under test.
module lu_sweeper #(
    parameter int unsigned SETTLE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] func_in,
    output logic       lu_a,
    output logic       lu_b,
    output logic [3:0] lu_func,
    input  logic       lu_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic       match
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_e;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] lu_func_q, lu_func_d;
    logic [3:0] result_q, result_d;
    logic       match_q, match_d;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= 4'd0;
            lu_func_q <= 4'd0;
            result_q  <= 4'd0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            lu_func_q <= lu_func_d;
            result_q  <= result_d;
            match_q   <= match_d;
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        lu_func_d = lu_func_q;
        result_d  = result_q;
        match_d   = match_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lu_func_d = func_in;
                    result_d  = 4'd0;
                    match_d   = 1'b0;
                    idx_d     = 2'd0;
                    cnt_d     = 4'd0;
                    state_d   = APPLY;
                end
            end
            APPLY: begin
                if (cnt_q != SETTLE_C) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    result_d[idx_q] = lu_out;
                    cnt_d           = 4'd0;
                    if (idx_q == 2'd3) begin
                        // idx returns to 0 here so the vector lines drop as the sweep ends
                        idx_d   = 2'd0;
                        match_d = (result_d == lu_func_q);
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign lu_a    = idx_q[1];
    assign lu_b    = idx_q[0];
    assign lu_func = lu_func_q;
    assign busy    = (state_q == APPLY);
    assign done    = (state_q == DONE);
    assign result  = result_q;
    assign match   = match_q;

endmodule

// File: tb/tb_lu_sweeper.sv
// Directed bench for lu_sweeper: one instance at SETTLE=0 and one at SETTLE=3,
// each driving a behavioural logical unit that can be correct or stuck at 0/1.
module tb_lu_sweeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start3 = 1'b0;
    logic [3:0] fin0 = 4'd0, fin3 = 4'd0;
    int         mode = 0;  // 0 correct unit, 1 stuck at 0, 2 stuck at 1

    logic       a0, b0, out0, busy0, done0, match0;
    logic [3:0] func0, result0;
    logic       a3, b3, out3, busy3, done3, match3;
    logic [3:0] func3, result3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign out0 = (mode == 0) ? func0[{a0, b0}] : (mode == 2);
    assign out3 = (mode == 0) ? func3[{a3, b3}] : (mode == 2);

    lu_sweeper #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .func_in(fin0),
        .lu_a(a0), .lu_b(b0), .lu_func(func0), .lu_out(out0),
        .busy(busy0), .done(done0), .result(result0), .match(match0)
    );

    lu_sweeper #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .func_in(fin3),
        .lu_a(a3), .lu_b(b3), .lu_func(func3), .lu_out(out3),
        .busy(busy3), .done(done3), .result(result3), .match(match3)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a sweep and return edges from the start edge until done is seen, plus busy cycles.
    task automatic sweep(input bit sel3, input logic [3:0] f, output int lat, output int busy_n);
        if (sel3) begin start3 = 1'b1; fin3 = f; end
        else      begin start0 = 1'b1; fin0 = f; end
        tick();
        start0 = 1'b0;
        start3 = 1'b0;
        fin0   = ~f;
        fin3   = ~f;
        lat    = 0;
        busy_n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sel3 ? done3 : done0) break;
            if (sel3 ? busy3 : busy0) busy_n++;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, bn, dones;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy_done", {busy0, done0, busy3, done3}, 8'h0);
        check("rst_ab_match", {a0, b0, match0, a3, b3, match3}, 8'h0);
        check("rst_func_result", {func0, result0}, 8'h00);
        tick();

        // Correct unit, SETTLE=0, func 1010: vector walk cycle by cycle
        mode   = 0;
        start0 = 1'b1;
        fin0   = 4'b1010;
        tick();
        start0 = 1'b0;
        fin0   = 4'b0101;
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            check($sformatf("t1_vec%0d", v), {busy0, done0, func0, a0, b0}, {1'b1, 1'b0, 4'b1010, 2'(v)});
            tick();
        end
        @(negedge clk);
        check("t1_done", {busy0, done0, a0, b0}, 8'b0100);
        check("t1_result_match", {result0, 3'b0, match0}, {4'b1010, 4'b0001});
        tick();
        @(negedge clk);
        check("t1_idle_hold", {done0, busy0, func0, result0, match0}, {2'b00, 4'b1010, 4'b1010, 1'b1});

        // Faulty units
        tick();
        mode = 1;
        sweep(1'b0, 4'b0110, lat, bn);
        check("t2a_latency", 8'(lat), 8'd4);
        check("t2a_busy", 8'(bn), 8'd4);
        check("t2a_result_match", {result0, 3'b0, match0}, {4'b0000, 4'b0000});
        tick();
        mode = 2;
        sweep(1'b0, 4'b0000, lat, bn);
        check("t2b_result_match", {result0, 3'b0, match0}, {4'b1111, 4'b0000});
        tick();

        // SETTLE=3, func 1001
        mode = 0;
        sweep(1'b1, 4'b1001, lat, bn);
        check("t3_latency", 8'(lat), 8'd16);
        check("t3_busy", 8'(bn), 8'd16);
        check("t3_result_match", {result3, 3'b0, match3}, {4'b1001, 4'b0001});
        tick();

        // Starts during APPLY and DONE are ignored
        start0 = 1'b1;
        fin0   = 4'b0001;
        tick();                              // edge T0
        fin0   = 4'b1111;                    // start held high into edge T0+2
        tick();                              // edge T0+1
        tick();                              // edge T0+2 (APPLY)
        start0 = 1'b0;
        @(negedge clk);
        check("t4_apply_func", {busy0, func0}, {4'b0001, 4'b0001});
        tick();                              // edge T0+3
        tick();                              // edge T0+4 -> DONE
        @(negedge clk);
        check("t4_done", {done0, result0, match0}, {1'b1, 4'b0001, 1'b1});
        start0 = 1'b1;
        tick();                              // edge T0+5 (DONE)
        start0 = 1'b0;
        @(negedge clk);
        check("t4_no_rebusy", {busy0, done0, func0}, {2'b00, 4'b0001});
        tick();
        @(negedge clk);
        check("t4_still_idle", {busy0, result0}, {1'b0, 4'b0001});
        tick();

        // Reset mid-sweep, then a fresh sweep
        start0 = 1'b1;
        fin0   = 4'b0110;
        tick();                              // edge T0
        start0 = 1'b0;
        tick();                              // edge T0+1
        rst = 1'b1;
        tick();                              // edge T0+2
        rst = 1'b0;
        @(negedge clk);
        check("t5_rst_ctl", {busy0, done0, a0, b0, match0}, 8'h0);
        check("t5_rst_data", {func0, result0}, 8'h00);
        tick();
        sweep(1'b0, 4'b1100, lat, bn);
        check("t5_latency", 8'(lat), 8'd4);
        check("t5_result_match", {result0, 3'b0, match0}, {4'b1100, 4'b0001});
        tick();

        // Back-to-back: second start in the IDLE cycle after done
        sweep(1'b0, 4'b0011, lat, bn);
        check("t6_first", {result0, 3'b0, match0}, {4'b0011, 4'b0001});
        tick();                              // DONE -> IDLE
        start0 = 1'b1;
        fin0   = 4'b0101;
        tick();                              // accepted
        start0 = 1'b0;
        @(negedge clk);
        check("t6_cleared", {busy0, func0, result0, match0}, {1'b1, 4'b0101, 4'b0000, 1'b0});
        tick();
        @(negedge clk);
        check("t6_partial", {busy0, result0, match0}, {1'b1, 4'b0001, 1'b0});
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done0) begin
                dones++;
                check("t6_second", {result0, 3'b0, match0}, {4'b0101, 4'b0001});
            end
            tick();
        end
        check("t6_done_count", 8'(dones), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lu_sweeper.md
# lu_sweeper

Sequential test driver and response collector for the 2-input logical unit (a, b, func[3:0] -> out). It sits on both sides of that unit: it drives a, b and func, walks the four input combinations, and captures out into a 4-bit result. It then reports whether the unit reproduced the requested function code. It provides the board-level self-check stage for the logical unit.

## Interface
- SETTLE, default 0: extra wait cycles per input vector before out is sampled; legal range 0..15.

- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a sweep; honoured only in IDLE
- func_in  input  4  function code to test; sampled only when start is accepted
- lu_a  output  1  drives logical unit input a
- lu_b  output  1  drives logical unit input b
- lu_func  output  4  drives logical unit func
- lu_out  input  1  logical unit output
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse when a sweep completes
- result  output  4  captured responses, bit i = lu_out observed with {lu_a,lu_b}=i
- match  output  1  result == lu_func; valid from done, held until next accepted start

## Operation
- Single clock domain; one synchronous, active-high reset.
- States: IDLE, APPLY, DONE.
- Internal registers: idx[1:0] (vector index) and cnt[3:0] (settle counter).
- Vector mapping: lu_a = idx[1], lu_b = idx[0].
- IDLE:
  - lu_a = lu_b = 0; busy = 0.
  - On start = 1: lu_func <= func_in, result <= 0, match <= 0, idx <= 0, cnt <= 0, go to APPLY.
- APPLY:
  - busy = 1.
  - If cnt != SETTLE: cnt <= cnt + 1.
  - If cnt == SETTLE: result[idx] <= lu_out, cnt <= 0.
    - If idx == 3: go to DONE.
    - Else: idx <= idx + 1.
- DONE (exactly one cycle):
  - done = 1, busy = 0, match = (result == lu_func), result final.
  - Return to IDLE; lu_a/lu_b drop to 0.
- start while in APPLY or DONE is ignored; no queueing.
- func_in changes outside the accept cycle have no effect.
- lu_func, result and match hold their values in IDLE until the next accepted start.
- match compares the full 4-bit result against lu_func; any single-bit mismatch gives 0.
- idx wraps only by leaving APPLY; it is never incremented past 3.
- Reset, including mid-sweep:
  - State -> IDLE; idx = cnt = 0.
  - lu_a = lu_b = 0, lu_func = 0, result = 0, match = 0, busy = 0, done = 0.
  - Any partial sweep is discarded.
- rst has priority over start in the same cycle.

## Timing
- Start is accepted at rising edge T0; busy is high from cycle T0+1.
- Each vector is held on lu_a/lu_b for SETTLE+1 cycles.
- lu_out is sampled at the last rising edge of that window, so the logical unit has SETTLE+1 full cycles to settle.
- Sampling edges:
  - Vector 0 ({a,b}=00): edge T0+(SETTLE+1).
  - Vector 1: edge T0+2(SETTLE+1).
  - Vector 2: edge T0+3(SETTLE+1).
  - Vector 3: edge T0+4(SETTLE+1).
- done = 1 during the cycle following edge T0+4(SETTLE+1); busy = 0 in that cycle.
- Latency: start edge to done high is 4(SETTLE+1) cycles, i.e. 4 cycles at SETTLE = 0.
- Start-to-start minimum period: 4(SETTLE+1)+2 cycles.
  - A start asserted in the done cycle is ignored.
  - A start asserted in the following IDLE cycle is accepted.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Correct unit, SETTLE=0, func_in=4'b1010, start pulse at T0:
  - lu_func=1010 from T0+1.
  - {lu_a,lu_b} = 00, 01, 10, 11 on cycles T0+1..T0+4.
  - done at T0+5 with result=1010, match=1.
- Faulty unit (lu_out tied 0), func_in=4'b0110: done after 4 busy cycles, result=0000, match=0; lu_out tied 1 with func_in=0000 gives result=1111, match=0.
- SETTLE=3, func_in=4'b1001, correct unit:
  - Each vector held 4 cycles; busy 16 cycles.
  - done 16 cycles after start edge; result=1001, match=1.
- Start pulses at T0+2 and T0+5 (during APPLY and DONE) with func_in=4'b1111, original sweep func_in=4'b0001:
  - Sweep unaffected; lu_func stays 0001, result=0001.
  - No second busy period begins.
- rst asserted at T0+2 mid-sweep: next cycle all outputs 0 and state IDLE. Fresh start with func_in=4'b1100 then completes normally with result=1100, match=1.
- Back-to-back sweeps, func_in=4'b0011 then 4'b0101 (second start one cycle after done): two done pulses; result/match update to 0101/1 only at the second done. result reads 0000 while the second sweep runs until its bits are captured.
